hazard_ctrl_pipe: RTL and testbench
===================================

Name: hazard_ctrl_pipe

Overview:
- Consumer end of the decoder's control-bundle interface.
- Takes the decoded control bundle plus register fields from the ID stage and carries it through the EX, MEM and WB stage registers.
- Detects load-use and branch-operand hazards, inserts bubbles, flushes IF/ID on taken branch or jump, and generates forwarding selects.
- Sits between the instruction decoder and the datapath pipeline registers of the 5-stage CPU.

Parameters:
REG_ADDR_W, 5, register-index width
ALUOP_W, 2, ALU-op field width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
stall_ext_i  in  1  external freeze (memory/cache stall)
id_valid_i  in  1  ID stage holds a real instruction
id_regdst_i, id_alusrc_i, id_regwrite_i, id_memtoreg_i, id_memwrite_i, id_isbranch_i, id_isjump_i  in  1 each  decoded control bits
id_aluop_i  in  ALUOP_W  decoded ALU op
id_rs_i, id_rt_i, id_rd_i  in  REG_ADDR_W each  instruction register fields
id_branch_eq_i  in  1  ID-stage comparator result (rs==rt)
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register enable
ifid_flush_o  out  1  zero IF/ID on next edge
pc_sel_o  out  2  00 sequential, 01 branch target, 10 jump target
ex_aluop_o  out  ALUOP_W  EX control
ex_alusrc_o  out  1  EX control
mem_memwrite_o, mem_memtoreg_o  out  1 each  MEM control
wb_regwrite_o  out  1  WB write enable (gated by valid)
wb_dst_o  out  REG_ADDR_W  WB destination
fwd_a_o, fwd_b_o  out  2 each  EX operand select: 00 regfile, 10 MEM, 01 WB
id_fwd_a_o, id_fwd_b_o  out  1 each  branch comparator takes MEM ALU result

Behaviour:
- Reset (async, rst_n_i=0):
  - All stage valids and controls are 0.
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, pc_sel_o=00, all forwarding selects 0.
- Stage registers:
  - EX/MEM/WB each hold the bundle, valid, rs, rt and dst.
  - dst = regdst ? rd : rt, latched at ID->EX.
  - Every control output is ANDed with its stage valid.
- uses_rt = id_regdst_i | id_memwrite_i | id_isbranch_i.
- Hazard stall (combinational, qualified by id_valid_i):
  - (a) Load-use: EX valid & memtoreg & dst!=0 & (dst==rs | (uses_rt & dst==rt)).
  - (b) Branch after ALU op: id_isbranch & EX regwrite & dst!=0 & matches rs/rt.
  - (c) Branch after load: id_isbranch & MEM memtoreg & dst!=0 & match.
  - Consequence: load->branch stalls 2 cycles, ALU->branch 1, load->use 1.
- On hazard stall:
  - pc_write_o=0, ifid_write_o=0, pc_sel_o=00, no flush.
  - EX receives a bubble (valid=0); MEM and WB advance.
- stall_ext_i=1 overrides everything:
  - All stage registers hold.
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, pc_sel_o=00.
- Taken branch (id_isbranch & id_branch_eq & no stall):
  - pc_sel_o=01, ifid_flush_o=1.
  - The branch itself enters EX as valid with regwrite=0.
- Jump: pc_sel_o=10, ifid_flush_o=1; never stalls.
- Priority: reset > stall_ext > hazard stall > branch/jump > sequential.
- EX forwarding, for each operand:
  - Select MEM (10) if MEM valid & regwrite & dst!=0 & dst==ex_rs/rt.
  - Else select WB (01) under the same test against WB.
  - Else 00.
- id_fwd_*: MEM valid & regwrite & !memtoreg & dst!=0 & dst==id_rs/rt.
- id_valid_i=0: no hazard, no branch, EX gets a bubble.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cnt_o[31:0] (counts hazard-stall cycles) and flush_cnt_o[31:0] (counts flush cycles).
  - Both counters saturate at 0xFFFFFFFF, clear on reset, and do not count while stall_ext_i=1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - ctrl_bundle_t struct (regdst, aluop, alusrc, regwrite, memtoreg, memwrite, isbranch, isjump).
  - pc_sel_e (SEQ, BR, JMP) and fwd_sel_e (RF, MEM, WB) enums.
  - Opcode constants (R_TYPE, ADDI, LW, SW, BEQ, JMP).
- One sub-module, ctrl_stage_reg: parameterised valid+bundle+reg-field register with enable, bubble and async reset.
  - Instantiated three times.

Test Plan:
- LW r2 in EX, ID ADD r3,r2,r4 -> one cycle pc_write_o=0, ifid_write_o=0, EX valid=0; next cycle fwd_a_o=10 after load reaches MEM? No: WB, so fwd_a_o=01.
- ADD r5,... in EX, ID BEQ r5,r0 taken -> one stall cycle, then id_fwd_a_o=1, pc_sel_o=01, ifid_flush_o=1 for exactly one cycle.
- LW r6 in EX, ID BEQ r6,r6 -> two stall cycles, then pc_sel_o=01.
- ID JMP with LW hazard pending in EX on r0 (dst=0) -> no stall, pc_sel_o=10, flush=1.
- stall_ext_i=1 for 3 cycles during a load-use stall -> all outputs frozen, pc_sel_o=00; after release the stall completes normally.
- Assert rst_n_i mid-stall -> outputs return to reset values immediately, without waiting for a clock edge; with HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the ID->EX->MEM->WB control pipeline and the hazard unit.
// Latency: none. This file holds types, constants and a reference decode function only.
// Backpressure: none. It is a package.
package ctrl_pkg;

    localparam int CTRL_ALUOP_W = 2;

    // Primary opcodes understood by the decoder feeding this block
    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] JMP    = 6'h02;

    localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic                    regdst;
        logic [CTRL_ALUOP_W-1:0] aluop;
        logic                    alusrc;
        logic                    regwrite;
        logic                    memtoreg;
        logic                    memwrite;
        logic                    isbranch;
        logic                    isjump;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_e;

    // Reference opcode decode, matching what the upstream decoder produces
    function automatic ctrl_bundle_t ctrl_decode(input logic [5:0] op);
        ctrl_bundle_t b;
        b = '0;
        case (op)
            R_TYPE: begin b.regdst = 1'b1; b.aluop = ALU_FUNCT; b.regwrite = 1'b1; end
            ADDI:   begin b.alusrc = 1'b1; b.aluop = ALU_ADD; b.regwrite = 1'b1; end
            LW:     begin b.alusrc = 1'b1; b.aluop = ALU_ADD; b.regwrite = 1'b1; b.memtoreg = 1'b1; end
            SW:     begin b.alusrc = 1'b1; b.aluop = ALU_ADD; b.memwrite = 1'b1; end
            BEQ:    begin b.aluop = ALU_SUB; b.isbranch = 1'b1; end
            JMP:    begin b.isjump = 1'b1; end
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: valid bit, control bundle, rs/rt and destination index.
// Latency: 1 cycle from inputs to outputs when enabled.
// Backpressure: en_i=0 holds the stage. bubble_i or valid_i=0 loads an empty (all-zero) slot.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  bubble_i,
    input  logic                  valid_i,
    input  ctrl_bundle_t          bundle_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic [REG_ADDR_W-1:0] dst_i,
    output logic                  valid_o,
    output ctrl_bundle_t          bundle_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [REG_ADDR_W-1:0] dst_o
);

    logic                  r_valid;
    ctrl_bundle_t          r_bundle;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_dst;

    // Hold when disabled; a bubble clears every field so stale indices never match
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_dst    <= '0;
        end else if (en_i) begin
            if (bubble_i || !valid_i) begin
                r_valid  <= 1'b0;
                r_bundle <= '0;
                r_rs     <= '0;
                r_rt     <= '0;
                r_dst    <= '0;
            end else begin
                r_valid  <= 1'b1;
                r_bundle <= bundle_i;
                r_rs     <= rs_i;
                r_rt     <= rt_i;
                r_dst    <= dst_i;
            end
        end
    end

    assign valid_o  = r_valid;
    assign bundle_o = r_bundle;
    assign rs_o     = r_rs;
    assign rt_o     = r_rt;
    assign dst_o    = r_dst;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Control pipeline EX/MEM/WB with load-use/branch hazard stalls, IF/ID flush and forwarding selects.
// Latency: stage controls move 1 cycle per stage. Hazard, PC and forward outputs are combinational.
// Backpressure: stall_ext_i freezes all stages. A hazard bubbles EX while MEM/WB drain. HAZARD_PERF_CNT_EN adds counters.
module hazard_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2   // must equal CTRL_ALUOP_W; the bundle carries a fixed-width op
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stall_ext_i,
    input  logic                  id_valid_i,
    input  logic                  id_regdst_i,
    input  logic                  id_alusrc_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memtoreg_i,
    input  logic                  id_memwrite_i,
    input  logic                  id_isbranch_i,
    input  logic                  id_isjump_i,
    input  logic [ALUOP_W-1:0]    id_aluop_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_branch_eq_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic [1:0]            pc_sel_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic                  ex_alusrc_o,
    output logic                  mem_memwrite_o,
    output logic                  mem_memtoreg_o,
    output logic                  wb_regwrite_o,
    output logic [REG_ADDR_W-1:0] wb_dst_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  id_fwd_a_o,
    output logic                  id_fwd_b_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    ctrl_bundle_t          w_id_b, w_ex_b, w_mem_b, w_wb_b;
    logic                  w_ex_vld, w_mem_vld, w_wb_vld;
    logic [REG_ADDR_W-1:0] w_id_dst;
    logic [REG_ADDR_W-1:0] w_ex_rs, w_ex_rt, w_ex_dst;
    logic [REG_ADDR_W-1:0] w_mem_rs, w_mem_rt, w_mem_dst;
    logic [REG_ADDR_W-1:0] w_wb_rs, w_wb_rt, w_wb_dst;
    logic                  w_adv;
    logic                  w_uses_rt, w_haz_lu, w_haz_br_ex, w_haz_br_mem, w_hazard;
    logic                  w_ex_hit_rs, w_ex_hit_rt, w_mem_hit_rs, w_mem_hit_rt;
    logic                  w_taken, w_jump;
    logic                  w_mem_wr, w_wb_wr;
    logic                  w_unused;

    // A branch never writes the register file, even if the decoder left regwrite set
    assign w_id_b = '{regdst:   id_regdst_i,
                      aluop:    id_aluop_i,
                      alusrc:   id_alusrc_i,
                      regwrite: id_regwrite_i & ~id_isbranch_i,
                      memtoreg: id_memtoreg_i,
                      memwrite: id_memwrite_i,
                      isbranch: id_isbranch_i,
                      isjump:   id_isjump_i};
    assign w_id_dst = id_regdst_i ? id_rd_i : id_rt_i;
    assign w_adv    = ~stall_ext_i;

    ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(w_adv), .bubble_i(w_hazard),
        .valid_i(id_valid_i), .bundle_i(w_id_b), .rs_i(id_rs_i), .rt_i(id_rt_i), .dst_i(w_id_dst),
        .valid_o(w_ex_vld), .bundle_o(w_ex_b), .rs_o(w_ex_rs), .rt_o(w_ex_rt), .dst_o(w_ex_dst)
    );

    ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(w_adv), .bubble_i(1'b0),
        .valid_i(w_ex_vld), .bundle_i(w_ex_b), .rs_i(w_ex_rs), .rt_i(w_ex_rt), .dst_i(w_ex_dst),
        .valid_o(w_mem_vld), .bundle_o(w_mem_b), .rs_o(w_mem_rs), .rt_o(w_mem_rt), .dst_o(w_mem_dst)
    );

    ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(w_adv), .bubble_i(1'b0),
        .valid_i(w_mem_vld), .bundle_i(w_mem_b), .rs_i(w_mem_rs), .rt_i(w_mem_rt), .dst_i(w_mem_dst),
        .valid_o(w_wb_vld), .bundle_o(w_wb_b), .rs_o(w_wb_rs), .rt_o(w_wb_rt), .dst_o(w_wb_dst)
    );

    // Hazard detection. Jumps read no registers here, so they are never held.
    assign w_uses_rt    = id_regdst_i | id_memwrite_i | id_isbranch_i;
    assign w_ex_hit_rs  = w_ex_vld  && (w_ex_dst  != '0) && (w_ex_dst  == id_rs_i);
    assign w_ex_hit_rt  = w_ex_vld  && (w_ex_dst  != '0) && (w_ex_dst  == id_rt_i);
    assign w_mem_hit_rs = w_mem_vld && (w_mem_dst != '0) && (w_mem_dst == id_rs_i);
    assign w_mem_hit_rt = w_mem_vld && (w_mem_dst != '0) && (w_mem_dst == id_rt_i);
    assign w_haz_lu     = w_ex_b.memtoreg && (w_ex_hit_rs || (w_uses_rt && w_ex_hit_rt));
    assign w_haz_br_ex  = id_isbranch_i && w_ex_b.regwrite && (w_ex_hit_rs || w_ex_hit_rt);
    assign w_haz_br_mem = id_isbranch_i && w_mem_b.memtoreg && (w_mem_hit_rs || w_mem_hit_rt);
    assign w_hazard     = id_valid_i && !id_isjump_i && (w_haz_lu || w_haz_br_ex || w_haz_br_mem);
    assign w_taken      = id_valid_i && id_isbranch_i && id_branch_eq_i && !w_hazard;
    assign w_jump       = id_valid_i && id_isjump_i;

    // PC/IF-ID steering. Reset is folded in so outputs go idle without waiting for a clock.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        pc_sel_o     = PC_SEQ;
        if (!rst_n_i) begin
            pc_write_o = 1'b1;
        end else if (stall_ext_i || w_hazard) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (w_taken) begin
            pc_sel_o     = PC_BR;
            ifid_flush_o = 1'b1;
        end else if (w_jump) begin
            pc_sel_o     = PC_JMP;
            ifid_flush_o = 1'b1;
        end
    end

    // Stage controls, each qualified by its own valid
    assign ex_aluop_o     = w_ex_b.aluop & {ALUOP_W{w_ex_vld}};
    assign ex_alusrc_o    = w_ex_b.alusrc   & w_ex_vld;
    assign mem_memwrite_o = w_mem_b.memwrite & w_mem_vld;
    assign mem_memtoreg_o = w_mem_b.memtoreg & w_mem_vld;
    assign wb_regwrite_o  = w_wb_b.regwrite  & w_wb_vld;
    assign wb_dst_o       = w_wb_dst & {REG_ADDR_W{w_wb_vld}};

    // Forwarding: the younger producer (MEM) wins over WB
    assign w_mem_wr   = w_mem_vld && w_mem_b.regwrite && (w_mem_dst != '0);
    assign w_wb_wr    = w_wb_vld  && w_wb_b.regwrite  && (w_wb_dst  != '0);
    assign fwd_a_o    = (w_mem_wr && w_mem_dst == w_ex_rs) ? FWD_MEM :
                        (w_wb_wr  && w_wb_dst  == w_ex_rs) ? FWD_WB  : FWD_RF;
    assign fwd_b_o    = (w_mem_wr && w_mem_dst == w_ex_rt) ? FWD_MEM :
                        (w_wb_wr  && w_wb_dst  == w_ex_rt) ? FWD_WB  : FWD_RF;
    // Branch compare in ID can only take an ALU result; load data is not ready yet
    assign id_fwd_a_o = w_mem_wr && !w_mem_b.memtoreg && (w_mem_dst == id_rs_i);
    assign id_fwd_b_o = w_mem_wr && !w_mem_b.memtoreg && (w_mem_dst == id_rt_i);

    // Fields carried for the datapath but not consumed by the control logic
    assign w_unused = ^{w_ex_b, w_mem_b, w_wb_b, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters, frozen while the pipeline is externally stalled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!stall_ext_i) begin
            if (w_hazard && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (ifid_flush_o && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Randomised and directed bench for hazard_ctrl_pipe against an in-flight instruction model.
// Latency: inputs are driven at negedge and outputs are sampled 2 time units later.
// Backpressure: the bench re-presents the ID instruction whenever the model says it was held.
module tb_hazard_ctrl_pipe;
    import ctrl_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       stall_ext_i, id_valid_i;
    logic       id_regdst_i, id_alusrc_i, id_regwrite_i, id_memtoreg_i, id_memwrite_i, id_isbranch_i, id_isjump_i;
    logic [1:0] id_aluop_i;
    logic [4:0] id_rs_i, id_rt_i, id_rd_i;
    logic       id_branch_eq_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o;
    logic [1:0] pc_sel_o, ex_aluop_o;
    logic       ex_alusrc_o, mem_memwrite_o, mem_memtoreg_o, wb_regwrite_o;
    logic [4:0] wb_dst_o;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic       id_fwd_a_o, id_fwd_b_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    hazard_ctrl_pipe #(.REG_ADDR_W(5), .ALUOP_W(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_ext_i(stall_ext_i), .id_valid_i(id_valid_i),
        .id_regdst_i(id_regdst_i), .id_alusrc_i(id_alusrc_i), .id_regwrite_i(id_regwrite_i),
        .id_memtoreg_i(id_memtoreg_i), .id_memwrite_i(id_memwrite_i), .id_isbranch_i(id_isbranch_i),
        .id_isjump_i(id_isjump_i), .id_aluop_i(id_aluop_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rd_i(id_rd_i), .id_branch_eq_i(id_branch_eq_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .pc_sel_o(pc_sel_o), .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o),
        .mem_memwrite_o(mem_memwrite_o), .mem_memtoreg_o(mem_memtoreg_o),
        .wb_regwrite_o(wb_regwrite_o), .wb_dst_o(wb_dst_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .id_fwd_a_o(id_fwd_a_o), .id_fwd_b_o(id_fwd_b_o)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // In-flight instruction model: index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit           vld;
        ctrl_bundle_t b;
        logic [4:0]   rs, rt, dst;
    } ent_t;

    ent_t         mp[3];
    int           n_vec = 0;
    int           n_err = 0;
    int unsigned  m_stall_cnt, m_flush_cnt;
    bit           last_stall, last_flush;
    bit           c_v, c_eq, c_ext;
    ctrl_bundle_t c_b;
    logic [5:0]   c_op;
    logic [4:0]   c_rs, c_rt, c_rd;
    logic         s_pcw, s_flush, s_idfa;
    logic [1:0]   s_sel;
    logic [5:0]   ops[6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            mp[i].vld = 0; mp[i].b = '0; mp[i].rs = 0; mp[i].rt = 0; mp[i].dst = 0;
        end
        m_stall_cnt = 0; m_flush_cnt = 0;
        last_stall = 0; last_flush = 0;
    endfunction

    // Must the ID instruction wait? Sources not yet producible at the point they are consumed.
    function automatic bit m_hazard();
        bit         st;
        bit         used;
        logic [4:0] s;
        st = 0;
        if (!c_v || c_b.isjump) return 0;
        for (int k = 0; k < 2; k++) begin
            s    = (k == 0) ? c_rs : c_rt;
            used = (k == 0) || c_b.regdst || c_b.memwrite || c_b.isbranch;
            if (used && s != 0) begin
                if (mp[0].vld && mp[0].dst == s && mp[0].b.memtoreg) st = 1;
                if (c_b.isbranch && mp[0].vld && mp[0].b.regwrite && mp[0].dst == s) st = 1;
                if (c_b.isbranch && mp[1].vld && mp[1].b.memtoreg && mp[1].dst == s) st = 1;
            end
        end
        return st;
    endfunction

    // Which later stage supplies the newest value of register src to EX
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src != 0 && mp[1].vld && mp[1].b.regwrite && mp[1].dst == src) return 2'b10;
        if (src != 0 && mp[2].vld && mp[2].b.regwrite && mp[2].dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_idfwd(input logic [4:0] src);
        return mp[1].vld && mp[1].b.regwrite && !mp[1].b.memtoreg && mp[1].dst != 0 && mp[1].dst == src;
    endfunction

    task automatic drive();
        stall_ext_i = c_ext; id_valid_i = c_v;
        id_regdst_i = c_b.regdst; id_alusrc_i = c_b.alusrc; id_regwrite_i = c_b.regwrite;
        id_memtoreg_i = c_b.memtoreg; id_memwrite_i = c_b.memwrite; id_isbranch_i = c_b.isbranch;
        id_isjump_i = c_b.isjump; id_aluop_i = c_b.aluop;
        id_rs_i = c_rs; id_rt_i = c_rt; id_rd_i = c_rd; id_branch_eq_i = c_eq;
    endtask

    // One clock: present an ID instruction, check all outputs, then advance the model
    task automatic step(input bit ext, input bit v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input bit eq);
        bit         haz, taken, jmp, e_flush;
        logic [1:0] e_sel;
        ent_t       nx;
        @(negedge clk_i);
        c_ext = ext; c_v = v; c_op = op; c_b = ctrl_decode(op);
        c_rs = rs; c_rt = rt; c_rd = rd; c_eq = eq;
        drive();
        #2;
        haz     = m_hazard();
        taken   = c_v && c_b.isbranch && eq && !haz;
        jmp     = c_v && c_b.isjump;
        e_flush = !ext && !haz && (taken || jmp);
        e_sel   = (ext || haz) ? 2'b00 : taken ? 2'b01 : jmp ? 2'b10 : 2'b00;
        chk("pc_write", pc_write_o, !(ext || haz));
        chk("ifid_write", ifid_write_o, !(ext || haz));
        chk("ifid_flush", ifid_flush_o, e_flush);
        chk("pc_sel", pc_sel_o, e_sel);
        chk("ex_aluop", ex_aluop_o, mp[0].vld ? mp[0].b.aluop : 2'b00);
        chk("ex_alusrc", ex_alusrc_o, mp[0].vld && mp[0].b.alusrc);
        chk("mem_memwrite", mem_memwrite_o, mp[1].vld && mp[1].b.memwrite);
        chk("mem_memtoreg", mem_memtoreg_o, mp[1].vld && mp[1].b.memtoreg);
        chk("wb_regwrite", wb_regwrite_o, mp[2].vld && mp[2].b.regwrite);
        if (mp[2].vld) chk("wb_dst", wb_dst_o, mp[2].dst);
        if (mp[0].vld) begin
            chk("fwd_a", fwd_a_o, m_fwd(mp[0].rs));
            chk("fwd_b", fwd_b_o, m_fwd(mp[0].rt));
        end
        chk("id_fwd_a", id_fwd_a_o, m_idfwd(rs));
        chk("id_fwd_b", id_fwd_b_o, m_idfwd(rt));
        s_pcw = pc_write_o; s_flush = ifid_flush_o; s_sel = pc_sel_o; s_idfa = id_fwd_a_o;
        if (!ext && haz) m_stall_cnt++;
        if (e_flush) m_flush_cnt++;
        @(posedge clk_i);
        if (!ext) begin
            nx.vld = v && !haz;
            nx.b = c_b;
            nx.b.regwrite = c_b.regwrite && !c_b.isbranch;
            nx.rs = rs; nx.rt = rt;
            nx.dst = c_b.regdst ? rd : rt;
            mp[2] = mp[1]; mp[1] = mp[0]; mp[0] = nx;
        end
        last_stall = ext || haz;
        last_flush = e_flush;
    endtask

    task automatic idle();
        step(0, 0, R_TYPE, 0, 0, 0, 0);
    endtask

    initial begin
        ops = '{R_TYPE, ADDI, LW, SW, BEQ, JMP};
        rst_n_i = 1'b0;
        c_ext = 0; c_v = 0; c_b = '0; c_rs = 0; c_rt = 0; c_rd = 0; c_eq = 0; c_op = R_TYPE;
        drive();
        model_clear();
        repeat (2) @(negedge clk_i);
        #2;
        chk("rst_pc_write", pc_write_o, 1);
        chk("rst_ifid_write", ifid_write_o, 1);
        chk("rst_flush", ifid_flush_o, 0);
        chk("rst_pc_sel", pc_sel_o, 0);
        chk("rst_fwd", {fwd_a_o, fwd_b_o, id_fwd_a_o, id_fwd_b_o}, 0);
        chk("rst_wb_regwrite", wb_regwrite_o, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_cnt", stall_cnt_o | flush_cnt_o, 0);
`endif
        rst_n_i = 1'b1;

        // Load-use: LW r2 then ADD r3,r2,r4 stalls once and later takes r2 from WB
        step(0, 1, LW, 1, 2, 0, 0);
        step(0, 1, R_TYPE, 2, 4, 3, 0);
        chk("lu_stall_pcw", s_pcw, 0);
        #3 chk("lu_ex_bubble", ex_aluop_o, 0);
        step(0, 1, R_TYPE, 2, 4, 3, 0);
        chk("lu_go_pcw", s_pcw, 1);
        #3 chk("lu_fwd_wb", fwd_a_o, 2'b01);
        idle();

        // ALU op then dependent taken branch: one stall, then ID forward and redirect
        step(0, 1, R_TYPE, 1, 1, 5, 0);
        step(0, 1, BEQ, 5, 0, 0, 1);
        chk("alubr_stall", s_pcw, 0);
        step(0, 1, BEQ, 5, 0, 0, 1);
        chk("alubr_sel", s_sel, 2'b01);
        chk("alubr_flush", s_flush, 1);
        chk("alubr_idfwd", s_idfa, 1);
        idle();
        chk("alubr_flush_once", s_flush, 0);

        // Load then dependent branch: two stalls
        step(0, 1, LW, 1, 6, 0, 0);
        step(0, 1, BEQ, 6, 6, 0, 1);
        chk("ldbr_stall1", s_pcw, 0);
        step(0, 1, BEQ, 6, 6, 0, 1);
        chk("ldbr_stall2", s_pcw, 0);
        step(0, 1, BEQ, 6, 6, 0, 1);
        chk("ldbr_sel", s_sel, 2'b01);
        idle();

        // Jump behind a load to r0: no stall
        step(0, 1, LW, 3, 0, 0, 0);
        step(0, 1, JMP, 0, 0, 0, 0);
        chk("jmp_sel", s_sel, 2'b10);
        chk("jmp_flush", s_flush, 1);
        idle();

        // External freeze during a load-use stall
        step(0, 1, LW, 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, R_TYPE, 2, 2, 7, 0);
            chk("ext_sel", s_sel, 0);
        end
        step(0, 1, R_TYPE, 2, 2, 7, 0);
        chk("ext_then_stall", s_pcw, 0);
        step(0, 1, R_TYPE, 2, 2, 7, 0);
        chk("ext_release", s_pcw, 1);
        idle();

        // Asynchronous reset in the middle of a load->branch stall
        step(0, 1, LW, 1, 6, 0, 0);
        step(0, 1, BEQ, 6, 6, 0, 1);
        @(negedge clk_i);
        #2 chk("prerst_memtoreg", mem_memtoreg_o, 1);
        chk("prerst_pcw", pc_write_o, 0);
        rst_n_i = 1'b0;
        #1;
        chk("arst_pcw", pc_write_o, 1);
        chk("arst_ifid_write", ifid_write_o, 1);
        chk("arst_memtoreg", mem_memtoreg_o, 0);
        chk("arst_pc_sel", pc_sel_o, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("arst_cnt", stall_cnt_o | flush_cnt_o, 0);
`endif
        model_clear();
        c_v = 0; drive();
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Random instruction stream over a small register set to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            bit ext;
            ext = ($urandom_range(0, 7) == 0);
            if (last_stall) begin
                step(ext, c_v, c_op, c_rs, c_rt, c_rd, c_eq);
            end else begin
                step(ext, last_flush ? 1'b0 : ($urandom_range(0, 7) != 0), ops[$urandom_range(0, 5)],
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        #3;
        chk("stall_cnt", stall_cnt_o, m_stall_cnt);
        chk("flush_cnt", flush_cnt_o, m_flush_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
